// File: rtl/t05_pkg.sv
// -----------------------------------------------------------------------------
// t05_pkg
// Shared definitions for the byte histogram block:
//   - default end-of-stream character and count-word width
//   - number of histogram bins
//   - FSM state encoding
//   - SRAM access direction encoding
// -----------------------------------------------------------------------------
package t05_pkg;

    localparam logic [7:0] EOF_CHAR_DEF = 8'h1A;
    localparam int         CNT_W_DEF    = 32;
    localparam int         HIST_BINS    = 256;

    typedef enum logic [3:0] {
        CLEAR_W,
        CLEAR_WAIT,
        IDLE,
        RD_REQ,
        RD_WAIT,
        INC,
        WR_REQ,
        WR_WAIT,
        DONE
    } state_e;

    typedef enum logic {
        SRAM_RD = 1'b0,
        SRAM_WR = 1'b1
    } sram_op_e;

endpackage

// File: rtl/t05_histogram.sv
// -----------------------------------------------------------------------------
// t05_histogram
// Counts occurrences of each byte value of an input stream in an external
// SRAM (one CNT_W-bit word per bin). After reset every bin is written to zero,
// then each accepted byte triggers a read-increment-write of its bin. The
// byte EOF_CHAR ends the stream and parks the block in a completed state.
//
// Ports
//   clk            single clock
//   rst            synchronous reset, active low
//   in_byte        incoming character
//   in_valid       in_byte is valid
//   in_ready       block accepts in_byte this cycle (IDLE only)
//   sram_done      one-cycle completion pulse from the SRAM interface
//   old_char       count read back, valid with sram_done on a read
//   hist_req       an SRAM access is pending
//   hist_r_wr      0 = read, 1 = write
//   histgram_addr  bin index
//   histogram      write data
//   total_count    number of non-EOF bytes counted (saturating)
//   hist_complete  high once EOF has been processed, until reset
// -----------------------------------------------------------------------------
module t05_histogram
    import t05_pkg::*;
#(
    parameter logic [7:0] EOF_CHAR = EOF_CHAR_DEF,
    parameter int         CNT_W    = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       in_byte,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sram_done,
    input  logic [CNT_W-1:0] old_char,
    output logic             hist_req,
    output logic             hist_r_wr,
    output logic [7:0]       histgram_addr,
    output logic [CNT_W-1:0] histogram,
    output logic [CNT_W-1:0] total_count,
    output logic             hist_complete
);

    localparam logic [7:0] LAST_BIN = 8'(HIST_BINS - 1);

    // State and datapath registers
    state_e           r_state;
    logic [7:0]       r_clr_idx;
    logic [7:0]       r_cur_byte;
    logic [CNT_W-1:0] r_old_cnt;
    logic [CNT_W-1:0] r_total;

    // Output registers
    logic             r_in_ready;
    logic             r_hist_req;
    sram_op_e         r_op;
    logic [7:0]       r_addr;
    logic [CNT_W-1:0] r_wdata;
    logic             r_complete;

    // Next-state and next-output values
    state_e           w_state_next;
    logic [7:0]       w_clr_idx_next;
    logic [7:0]       w_cur_byte_next;
    logic             w_in_ready_d;
    logic             w_hist_req_d;
    sram_op_e         w_op_d;
    logic [7:0]       w_addr_d;
    logic [CNT_W-1:0] w_wdata_d;
    logic             w_complete_d;

    // Saturating incrementers: an all-ones value stays all-ones.
    logic [CNT_W-1:0] w_new_cnt;
    logic [CNT_W-1:0] w_total_inc;

    assign w_new_cnt   = (&r_old_cnt) ? r_old_cnt : r_old_cnt + CNT_W'(1);
    assign w_total_inc = (&r_total)   ? r_total   : r_total   + CNT_W'(1);

    // Next-state logic. Transitions out of a request are taken only from the
    // matching WAIT state, so a stray sram_done anywhere else has no effect.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        w_state_next    = r_state;
        w_clr_idx_next  = r_clr_idx;
        w_cur_byte_next = r_cur_byte;

        case (r_state)
            CLEAR_W:    w_state_next = CLEAR_WAIT;
            CLEAR_WAIT: begin
                if (sram_done) begin
                    if (r_clr_idx == LAST_BIN) begin
                        w_state_next = IDLE;
                    end else begin
                        w_clr_idx_next = r_clr_idx + 8'd1;
                        w_state_next   = CLEAR_W;
                    end
                end
            end
            IDLE: begin
                if (in_valid) begin
                    w_cur_byte_next = in_byte;
                    w_state_next    = (in_byte == EOF_CHAR) ? DONE : RD_REQ;
                end
            end
            RD_REQ:     w_state_next = RD_WAIT;
            RD_WAIT:    if (sram_done) w_state_next = INC;
            INC:        w_state_next = WR_REQ;
            WR_REQ:     w_state_next = WR_WAIT;
            WR_WAIT:    if (sram_done) w_state_next = IDLE;
            DONE:       w_state_next = DONE;
            default:    w_state_next = CLEAR_W;
        endcase
    end

    // Outputs are decoded from the *next* state and registered, so they line
    // up with the state they belong to while depending on no input
    // combinationally. The cycle right after reset is the one exception:
    // everything reads 0 while the FSM sits in its first CLEAR_W.
    always_comb begin
        w_in_ready_d = 1'b0;
        w_hist_req_d = 1'b0;
        w_op_d       = SRAM_RD;
        w_addr_d     = 8'd0;
        w_wdata_d    = '0;
        w_complete_d = 1'b0;

        case (w_state_next)
            CLEAR_W, CLEAR_WAIT: begin
                w_hist_req_d = 1'b1;
                w_op_d       = SRAM_WR;
                w_addr_d     = w_clr_idx_next;
            end
            IDLE: w_in_ready_d = 1'b1;
            RD_REQ, RD_WAIT: begin
                w_hist_req_d = 1'b1;
                w_addr_d     = w_cur_byte_next;
            end
            WR_REQ, WR_WAIT: begin
                // r_old_cnt is frozen from INC until the write completes.
                w_hist_req_d = 1'b1;
                w_op_d       = SRAM_WR;
                w_addr_d     = w_cur_byte_next;
                w_wdata_d    = w_new_cnt;
            end
            DONE: w_complete_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register here
        // samples values from before the edge regardless of statement order.
        if (!rst) begin
            r_state    <= CLEAR_W;
            r_clr_idx  <= 8'd0;
            r_cur_byte <= 8'd0;
            r_old_cnt  <= '0;
            r_total    <= '0;
            r_in_ready <= 1'b0;
            r_hist_req <= 1'b0;
            r_op       <= SRAM_RD;
            r_addr     <= 8'd0;
            r_wdata    <= '0;
            r_complete <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_clr_idx  <= w_clr_idx_next;
            r_cur_byte <= w_cur_byte_next;
            if (r_state == RD_WAIT && sram_done) begin
                r_old_cnt <= old_char;
            end
            if (r_state == INC) begin
                r_total <= w_total_inc;
            end
            r_in_ready <= w_in_ready_d;
            r_hist_req <= w_hist_req_d;
            r_op       <= w_op_d;
            r_addr     <= w_addr_d;
            r_wdata    <= w_wdata_d;
            r_complete <= w_complete_d;
        end
    end

    assign in_ready      = r_in_ready;
    assign hist_req      = r_hist_req;
    assign hist_r_wr     = r_op;
    assign histgram_addr = r_addr;
    assign histogram     = r_wdata;
    assign total_count   = r_total;
    assign hist_complete = r_complete;

endmodule

// File: tb/tb_t05_histogram.sv
// -----------------------------------------------------------------------------
// tb_t05_histogram
// Directed bench for t05_histogram. A behavioural SRAM answers each access
// a programmable number of cycles after hist_req is seen, and logs reads and
// writes so the directed steps can compare against hand-computed values.
// -----------------------------------------------------------------------------
module tb_t05_histogram;

    localparam int CW = 32;

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic [7:0]    in_byte  = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          sram_done;
    logic [CW-1:0] old_char;
    logic          hist_req;
    logic          hist_r_wr;
    logic [7:0]    histgram_addr;
    logic [CW-1:0] histogram;
    logic [CW-1:0] total_count;
    logic          hist_complete;

    int n_checks = 0;
    int n_fail   = 0;

    // SRAM model state
    logic [CW-1:0] mem [256];
    logic          m_busy       = 1'b0;
    logic          m_done       = 1'b0;
    int            m_cnt        = 0;
    logic [CW-1:0] m_rdata      = '0;
    int            n_rd         = 0;
    int            n_wr         = 0;
    int            sweep_bad    = 0;
    logic [7:0]    last_wr_addr = 8'd0;
    logic [CW-1:0] last_wr_data = '0;
    int            lat          = 2;
    logic          spur         = 1'b0;
    logic          pre_en       = 1'b0;
    logic [7:0]    pre_addr     = 8'd0;
    logic [CW-1:0] pre_data     = '0;

    assign sram_done = m_done | spur;
    assign old_char  = m_rdata;

    t05_histogram #(
        .EOF_CHAR (8'h1A),
        .CNT_W    (CW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_byte       (in_byte),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .sram_done     (sram_done),
        .old_char      (old_char),
        .hist_req      (hist_req),
        .hist_r_wr     (hist_r_wr),
        .histgram_addr (histgram_addr),
        .histogram     (histogram),
        .total_count   (total_count),
        .hist_complete (hist_complete)
    );

    always #5 clk = ~clk;

    // SRAM: starts an access when hist_req is seen, completes it `lat`
    // negedges later with a one-cycle done pulse. The first 256 writes after
    // a reset must be the zero sweep over bins 0..255 in order.
    always @(negedge clk) begin
        if (pre_en) mem[pre_addr] <= pre_data;
        if (!rst) begin
            m_busy    <= 1'b0;
            m_done    <= 1'b0;
            n_rd      <= 0;
            n_wr      <= 0;
            sweep_bad <= 0;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_busy) begin
            if (m_cnt == 1) begin
                m_done <= 1'b1;
                m_busy <= 1'b0;
                if (hist_r_wr) begin
                    mem[histgram_addr] <= histogram;
                    last_wr_addr       <= histgram_addr;
                    last_wr_data       <= histogram;
                    n_wr               <= n_wr + 1;
                    if (n_wr < 256 && (histgram_addr != 8'(n_wr) || histogram != '0))
                        sweep_bad <= sweep_bad + 1;
                end else begin
                    m_rdata <= mem[histgram_addr];
                    n_rd    <= n_rd + 1;
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (hist_req) begin
            m_busy <= 1'b1;
            m_cnt  <= lat;
        end
    end

    task automatic check(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag, input int budget, output int cyc);
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_ready"}, CW'(in_ready), 32'd1);
    endtask

    // Called on a negedge with in_ready high; returns one negedge later.
    task automatic send(input logic [7:0] b);
        in_byte  = b;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int rd0;
        int wr0;

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_req",      CW'(hist_req),      32'd0);
        check("rst_wr",       CW'(hist_r_wr),     32'd0);
        check("rst_addr",     CW'(histgram_addr), 32'd0);
        check("rst_wdata",    histogram,          32'd0);
        check("rst_ready",    CW'(in_ready),      32'd0);
        check("rst_complete", CW'(hist_complete), 32'd0);
        check("rst_total",    total_count,        32'd0);

        // Clear sweep
        rst = 1'b1;
        wait_ready("sweep", 4000, cyc);
        check("sweep_writes", CW'(n_wr),         32'd256);
        check("sweep_order",  CW'(sweep_bad),    32'd0);
        check("sweep_reads",  CW'(n_rd),         32'd0);
        check("sweep_last",   CW'(last_wr_addr), 32'hFF);
        check("idle_req",     CW'(hist_req),     32'd0);

        // 0x41, 0x41, 0x42
        send(8'h41);
        wait_ready("b1", 100, cyc);
        check("lat_b1",   CW'(cyc),          32'd7);
        check("b1_total", total_count,       32'd1);
        send(8'h41);
        wait_ready("b2", 100, cyc);
        check("b2_addr",  CW'(last_wr_addr), 32'h41);
        check("b2_data",  last_wr_data,      32'd2);
        send(8'h42);
        wait_ready("b3", 100, cyc);
        check("b3_addr",  CW'(last_wr_addr), 32'h42);
        check("b3_data",  last_wr_data,      32'd1);
        check("b3_total", total_count,       32'd3);
        check("b3_reads", CW'(n_rd),         32'd3);
        check("b3_wr",    CW'(n_wr),         32'd259);
        check("bin41",    mem[8'h41],        32'd2);

        // Saturation: bin 7 preloaded with all ones
        @(posedge clk);
        pre_addr = 8'h07;
        pre_data = 32'hFFFF_FFFF;
        pre_en   = 1'b1;
        @(posedge clk);
        pre_en   = 1'b0;
        @(negedge clk);
        send(8'h07);
        wait_ready("sat", 100, cyc);
        check("sat_addr",  CW'(last_wr_addr), 32'h07);
        check("sat_data",  last_wr_data,      32'hFFFF_FFFF);
        check("sat_total", total_count,       32'd4);

        // Spurious done pulse while idle
        spur = 1'b1;
        @(negedge clk);
        spur = 1'b0;
        repeat (3) @(negedge clk);
        check("spur_ready", CW'(in_ready), 32'd1);
        check("spur_req",   CW'(hist_req), 32'd0);
        check("spur_total", total_count,   32'd4);

        // in_valid held through a 10-cycle SRAM stall
        lat = 10;
        rd0 = n_rd;
        wr0 = n_wr;
        in_byte  = 8'h55;
        in_valid = 1'b1;
        @(negedge clk);
        repeat (5) @(negedge clk);
        check("stall_req",   CW'(hist_req),      32'd1);
        check("stall_rw",    CW'(hist_r_wr),     32'd0);
        check("stall_addr",  CW'(histgram_addr), 32'h55);
        check("stall_ready", CW'(in_ready),      32'd0);
        check("stall_total", total_count,        32'd4);
        wait_ready("stall", 100, cyc);
        in_valid = 1'b0;
        check("lat_stall",   CW'(cyc),           32'd18);
        repeat (10) @(negedge clk);
        check("stall_cnt",   total_count,        32'd5);
        check("stall_rd",    CW'(n_rd - rd0),    32'd1);
        check("stall_wrn",   CW'(n_wr - wr0),    32'd1);
        check("stall_data",  mem[8'h55],         32'd1);
        lat = 2;

        // EOF after five counted bytes
        rd0 = n_rd;
        wr0 = n_wr;
        send(8'h1A);
        check("eof_complete", CW'(hist_complete), 32'd1);
        check("eof_ready",    CW'(in_ready),      32'd0);
        check("eof_req",      CW'(hist_req),      32'd0);
        in_byte  = 8'h20;
        in_valid = 1'b1;
        repeat (8) @(negedge clk);
        in_valid = 1'b0;
        check("done_total",    total_count,        32'd5);
        check("done_complete", CW'(hist_complete), 32'd1);
        check("done_ready",    CW'(in_ready),      32'd0);
        check("done_rd",       CW'(n_rd - rd0),    32'd0);
        check("done_wr",       CW'(n_wr - wr0),    32'd0);

        // Leave DONE, then reset in the middle of a read of 0x30
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wait_ready("sweep2", 4000, cyc);
        send(8'h30);
        @(negedge clk);
        check("rdwait_req", CW'(hist_req), 32'd1);
        rst = 1'b0;
        @(negedge clk);
        check("mid_req",      CW'(hist_req),      32'd0);
        check("mid_complete", CW'(hist_complete), 32'd0);
        check("mid_total",    total_count,        32'd0);
        check("mid_ready",    CW'(in_ready),      32'd0);
        @(negedge clk);
        rst = 1'b1;
        wait_ready("sweep3", 4000, cyc);
        check("sweep3_writes", CW'(n_wr),      32'd256);
        check("sweep3_order",  CW'(sweep_bad), 32'd0);
        check("sweep3_bin41",  mem[8'h41],     32'd0);
        check("sweep3_total",  total_count,    32'd0);
        send(8'h30);
        wait_ready("post", 100, cyc);
        check("post_addr",  CW'(last_wr_addr), 32'h30);
        check("post_data",  last_wr_data,      32'd1);
        check("post_total", total_count,       32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/t05_histogram.md
T05_HISTOGRAM -- requirements
Module: t05_histogram

Interface
REQ-001 SHALL take parameter EOF_CHAR, default 8'h1A, the byte value that ends the input stream.
REQ-002 SHALL take parameter CNT_W, default 32, the width of each count word.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 SHALL have port in_byte, input, 8 bits: incoming character.
REQ-006 SHALL have port in_valid, input, 1 bit: in_byte is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block accepts in_byte this cycle.
REQ-008 SHALL have port sram_done, input, 1 bit: one-cycle pulse from the SRAM interface when the current access completes.
REQ-009 SHALL have port old_char, input, CNT_W bits: count read back from the SRAM interface, valid while sram_done=1 on a read.
REQ-010 SHALL have port hist_req, output, 1 bit: an SRAM access is pending.
REQ-011 SHALL have port hist_r_wr, output, 1 bit: 0 means read, 1 means write.
REQ-012 SHALL have port histgram_addr, output, 8 bits: bin index.
REQ-013 SHALL have port histogram, output, CNT_W bits: write data.
REQ-014 SHALL have port total_count, output, CNT_W bits: number of non-EOF bytes counted.
REQ-015 SHALL have port hist_complete, output, 1 bit: level signal, high after EOF is processed, until reset.

Function
REQ-016 SHALL implement an FSM with states CLEAR_W, CLEAR_WAIT, IDLE, RD_REQ, RD_WAIT, INC, WR_REQ, WR_WAIT, DONE.
REQ-017 After reset, SHALL clear all 256 bins to 0:
- CLEAR_W drives hist_req=1, hist_r_wr=1, histgram_addr=clr_idx, histogram=0.
- The FSM moves to CLEAR_WAIT and holds there until sram_done.
- clr_idx then increments; after bin 255 the FSM goes to IDLE.
REQ-018 in_ready SHALL be 1 only in IDLE; a byte is accepted when in_valid and in_ready are both 1 on a clock edge, and is latched into cur_byte.
REQ-019 An accepted byte equal to EOF_CHAR SHALL move the FSM to DONE without counting the byte and without any SRAM access.
REQ-020 Any other accepted byte SHALL move the FSM to RD_REQ.
REQ-021 RD_REQ and RD_WAIT SHALL drive hist_req=1, hist_r_wr=0, histgram_addr=cur_byte.
REQ-022 On sram_done in RD_WAIT, old_char SHALL be latched and the FSM SHALL go to INC.
REQ-023 INC SHALL compute new count = old_char+1, saturating at all-ones (no wrap), and SHALL increment total_count, also saturating.
REQ-024 WR_REQ and WR_WAIT SHALL drive hist_req=1, hist_r_wr=1, histgram_addr=cur_byte, histogram=new count.
REQ-025 On sram_done in WR_WAIT, the FSM SHALL return to IDLE.
REQ-026 Latency SHALL be at least 6 cycles from accept to the next in_ready, plus SRAM wait cycles.
REQ-027 sram_done arriving while hist_req=0, or in a REQ state, SHALL be ignored; any state transition is taken only from a WAIT state.
REQ-028 hist_req SHALL stay constant within RD_REQ/RD_WAIT, within WR_REQ/WR_WAIT, and within CLEAR_W/CLEAR_WAIT; it SHALL be 0 in IDLE, INC and DONE.
REQ-029 DONE SHALL be absorbing: hist_complete=1, in_ready=0, hist_req=0, and input is ignored.
REQ-030 Outputs SHALL be registered; no output depends combinationally on in_valid, sram_done or old_char.

Reset
REQ-031 rst=0 at any clock edge SHALL force state=CLEAR_W and clr_idx=0.
REQ-032 Reset SHALL set to 0: total_count, cur_byte, the latched count, hist_req, hist_r_wr, histgram_addr, histogram, in_ready and hist_complete.
REQ-033 Reset mid-access SHALL abandon the transaction, with hist_req=0 on the following cycle, and restart the clear sweep.

Structure
REQ-034 The FSM state enum, EOF_CHAR default, HIST_BINS=256 and the CNT_W default SHALL live in shared package t05_pkg alongside the SRAM interface enums.
REQ-035 The block SHALL be a single module with no sub-modules; the saturating incrementer SHALL be inline logic.

Verification
REQ-036 Reset released, SRAM model answers each access after 2 cycles -> 256 write requests with data 0, addresses 0..255 in order; then in_ready=1.
REQ-037 Bytes 8'h41, 8'h41, 8'h42 -> read/write pairs; last write to bin 0x41 carries 2, write to bin 0x42 carries 1; total_count=3.
REQ-038 Bin 0x07 preloaded with 32'hFFFF_FFFF, byte 8'h07 -> write data 32'hFFFF_FFFF (saturated).
REQ-039 Byte 8'h1A after 5 counted bytes -> no SRAM access; hist_complete=1; total_count=5; further in_valid ignored.
REQ-040 rst=0 during RD_WAIT of byte 8'h30 -> next cycle hist_req=0, hist_complete=0, total_count=0; clear sweep restarts at addr 0.
REQ-041 Spurious sram_done pulse in IDLE, plus in_valid held through a 10-cycle SRAM stall -> no state change; exactly one count per accepted handshake.
